// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam logic [1:0] MEMW_NONE  = 2'd0;
   localparam logic [1:0] MEMW_WORD  = 2'd1;
   localparam logic [1:0] MEMW_BYTE  = 2'd2;
   localparam logic [1:0] MEMW_DWORD = 2'd3;

   // Counter width that stays legal when the count range collapses to one value.
   function automatic int width_min1(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_beat_timer.sv
// Per-beat wait counter: loads LAT-1, counts down to zero and holds there.
module beat_timer
   import mem_arb_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = width_min1(LAT);
   localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between I-cache refills and
// D-cache refills/writebacks, moving one line beat by beat with a fixed wait per beat.
//
// state | meaning
// IDLE  | arbitrate pending requests
// WAIT  | memory wait cycles before the current beat
// XFER  | one beat moves on the memory port
// DONE  | line finished, owner's done pulses
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N     = 64,
   parameter int BEATS = 4,
   parameter int LAT   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_req,
   input  logic [31:0]              i_adr,
   input  logic                     i_cancel,
   output logic                     i_gnt,
   output logic                     i_rvalid,
   output logic                     i_done,
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [N-1:0]             d_adr,
   input  logic [N-1:0]             d_wdata,
   output logic                     d_gnt,
   output logic                     d_rvalid,
   output logic                     d_done,
   output logic [$clog2(BEATS)-1:0] beat,
   output logic [N-1:0]             rdata,
   output logic [N-1:0]             mem_adr,
   output logic [1:0]               mem_write,
   output logic [N-1:0]             mem_wdata,
   input  logic [N-1:0]             mem_rdata
);

   localparam int BW = $clog2(BEATS);
   localparam logic [N-1:0] ALIGN_MASK = ~((N'(1) << (BW + 3)) - N'(1));
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   state_t     state;
   owner_t     owner;
   owner_t     last_owner;
   logic [N-1:0] base;
   logic       we;
   logic       grant_i;
   logic       grant_d;
   logic       cancel_hit;
   logic       last_beat;
   logic       tmr_load;
   logic       tmr_dec;
   logic       tmr_zero;

   // On a tie the requester that did not own the previous line wins.
   assign grant_d    = d_req && (!i_req || (last_owner == OWN_I));
   assign grant_i    = i_req && !grant_d;
   assign cancel_hit = i_cancel && (owner == OWN_I) && ((state == WAIT) || (state == XFER));
   assign last_beat  = (beat == LAST_BEAT);

   assign tmr_load = ((state == IDLE) && (grant_i || grant_d)) ||
                     ((state == XFER) && !last_beat);
   assign tmr_dec  = (state == WAIT);

   beat_timer #(.LAT(LAT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .dec   (tmr_dec),
      .zero  (tmr_zero)
   );

   assign mem_adr   = base + (N'(beat) << 3);
   assign mem_write = ((state == XFER) && (owner == OWN_D) && we) ? MEMW_DWORD : MEMW_NONE;
   assign mem_wdata = d_wdata;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= OWN_I;
         last_owner <= OWN_I;
         base       <= '0;
         we         <= 1'b0;
         beat       <= '0;
         rdata      <= '0;
         i_gnt      <= 1'b0;
         d_gnt      <= 1'b0;
         i_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  owner <= OWN_D;
                  base  <= d_adr & ALIGN_MASK;
                  we    <= d_we;
                  beat  <= '0;
                  d_gnt <= 1'b1;
                  state <= WAIT;
               end else if (grant_i) begin
                  owner <= OWN_I;
                  base  <= N'(i_adr) & ALIGN_MASK;
                  we    <= 1'b0;
                  beat  <= '0;
                  i_gnt <= 1'b1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cancel_hit) begin
                  i_gnt      <= 1'b0;
                  last_owner <= OWN_I;
                  state      <= IDLE;
               end else if (tmr_zero) begin
                  state <= XFER;
               end
            end
            XFER: begin
               if (cancel_hit) begin
                  i_gnt      <= 1'b0;
                  last_owner <= OWN_I;
                  state      <= IDLE;
               end else begin
                  if (!we) begin
                     rdata    <= mem_rdata;
                     i_rvalid <= (owner == OWN_I);
                     d_rvalid <= (owner == OWN_D);
                  end
                  if (last_beat) begin
                     i_done <= (owner == OWN_I);
                     d_done <= (owner == OWN_D);
                     state  <= DONE;
                  end else begin
                     beat  <= beat + BW'(1);
                     state <= WAIT;
                  end
               end
            end
            DONE: begin
               last_owner <= owner;
               i_gnt      <= 1'b0;
               d_gnt      <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of line transfers checked cycle by cycle, a read/write
// scoreboard, and hand-written tie, cancel and mid-transfer reset sequences.
module tb_mem_arbiter;

   localparam int N     = 64;
   localparam int BEATS = 4;
   localparam int LAT   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, i_cancel, i_gnt, i_rvalid, i_done;
   logic [31:0]   i_adr;
   logic          d_req, d_we, d_gnt, d_rvalid, d_done;
   logic [N-1:0]  d_adr, d_wdata;
   logic [1:0]    beat;
   logic [N-1:0]  rdata, mem_adr, mem_wdata, mem_rdata;
   logic [1:0]    mem_write;

   logic [63:0]   ram [0:127];
   bit            ram_init;
   bit            sb_en;

   int            n_pass  = 0;
   int            n_total = 0;

   logic [63:0]   iq[$];
   logic [63:0]   dq[$];
   logic [63:0]   wq_adr[$];
   logic [63:0]   wq_dat[$];

   typedef struct {
      bit          is_d;
      bit          we;
      logic [63:0] adr;
      logic [63:0] exp_base;
   } vec_t;

   vec_t vec [4];

   mem_arbiter #(.N(N), .BEATS(BEATS), .LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_adr     (i_adr),
      .i_cancel  (i_cancel),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_done    (i_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_adr     (d_adr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_done    (d_done),
      .beat      (beat),
      .rdata     (rdata),
      .mem_adr   (mem_adr),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign d_wdata   = 64'hA0 + 64'(beat);
   assign mem_rdata = ram[mem_adr[9:3]];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int k = 0; k < 128; k++) ram[k] <= 64'(k);
      end else if (mem_write == 2'd3) begin
         ram[mem_adr[9:3]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: expected beats are queued when a transfer is launched.
   always @(negedge clk) begin
      if (sb_en) begin
         if (i_rvalid) begin
            if (iq.size() == 0) chk("i_rvalid_unexpected", {63'd0, i_rvalid}, 64'd0);
            else chk("i_rdata", rdata, iq.pop_front());
         end
         if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", {63'd0, d_rvalid}, 64'd0);
            else chk("d_rdata", rdata, dq.pop_front());
         end
         if (mem_write != 2'd0) begin
            chk("mem_write_code", 64'(mem_write), 64'd3);
            if (wq_adr.size() == 0) chk("write_unexpected", 64'(mem_write), 64'd0);
            else begin
               chk("wr_adr", mem_adr, wq_adr.pop_front());
               chk("wr_data", mem_wdata, wq_dat.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int w = 0; w < 10; w++) begin
         @(negedge clk);
         if (is_d ? d_gnt : i_gnt) begin
            ok = 1'b1;
            break;
         end
      end
      chk("grant_wait", {63'd0, (is_d ? d_gnt : i_gnt)}, 64'd1);
   endtask

   task automatic run_txn(input vec_t v);
      bit          ok;
      logic [7:0]  act, exp;
      bit          rv_exp;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_adr = v.adr;
      end else begin
         i_req = 1'b1; i_adr = v.adr[31:0];
      end
      for (int b = 0; b < BEATS; b++) begin
         if (v.we) begin
            wq_adr.push_back(v.exp_base + 64'(b * 8));
            wq_dat.push_back(64'hA0 + 64'(b));
         end else if (v.is_d) dq.push_back((v.exp_base >> 3) + 64'(b));
         else iq.push_back((v.exp_base >> 3) + 64'(b));
      end
      wait_gnt(v.is_d, ok);
      if (!ok) return;
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) @(negedge clk);
         rv_exp = !v.we && (k >= 4) && (k % 4 == 0);
         act = v.is_d ? {d_gnt, i_gnt, d_rvalid, i_rvalid, d_done, i_done, mem_write}
                      : {i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_write};
         exp = {1'b1, 1'b0, rv_exp, 1'b0, (k == 16), 1'b0,
                ((v.we && (k % 4 == 3)) ? 2'd3 : 2'd0)};
         chk($sformatf("cycle%0d_ctl", k), 64'(act), 64'(exp));
         if (k % 4 == 3) begin
            chk("xfer_adr", mem_adr, v.exp_base + 64'((k / 4) * 8));
            chk("xfer_beat", 64'(beat), 64'(k / 4));
         end
      end
      if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
      @(negedge clk);
      chk("gnt_release", {62'd0, i_gnt, d_gnt}, 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      bit   ok;
      int   gseq [3];
      int   ng, t_ddone, t_irise, cyc, n_irv, n_idone;
      logic pi, pd;

      vec[0] = '{is_d: 1'b0, we: 1'b0, adr: 64'h40,  exp_base: 64'h40};
      vec[1] = '{is_d: 1'b0, we: 1'b0, adr: 64'h4C,  exp_base: 64'h40};
      vec[2] = '{is_d: 1'b1, we: 1'b1, adr: 64'h100, exp_base: 64'h100};
      vec[3] = '{is_d: 1'b1, we: 1'b0, adr: 64'h200, exp_base: 64'h200};

      reset = 1'b0; i_req = 1'b0; i_adr = '0; i_cancel = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_adr = '0; sb_en = 1'b0;
      ram_init = 1'b1;
      tick();
      tick();
      ram_init = 1'b0;
      @(negedge clk);
      chk("reset_ctl", {56'd0, i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_write}, 64'd0);
      chk("reset_beat", 64'(beat), 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      tick();
      reset = 1'b1;
      sb_en = 1'b1;

      for (int i = 0; i < 4; i++) begin
         run_txn(vec[i]);
         tick();
      end
      for (int k = 0; k < 4; k++) chk("wb_ram", ram[32 + k], 64'hA0 + 64'(k));

      // Tie after reset: D first, then alternation while both stay requested.
      sb_en = 1'b0;
      do_reset();
      i_adr = 32'h40; d_adr = 64'h200; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      ng = 0; t_ddone = -100; t_irise = -1; pi = 1'b0; pd = 1'b0;
      for (int c = 0; c < 80 && ng < 3; c++) begin
         @(negedge clk);
         if (d_gnt && !pd) begin gseq[ng] = 1; ng++; end
         if (i_gnt && !pi) begin
            gseq[ng] = 0; ng++;
            if (t_irise < 0) t_irise = c;
         end
         if (d_done && t_ddone < 0) t_ddone = c;
         pi = i_gnt; pd = d_gnt;
      end
      chk("tie_grant_count", 64'(ng), 64'd3);
      chk("tie_order", {61'd0, 1'(gseq[0]), 1'(gseq[1]), 1'(gseq[2])}, 64'b101);
      chk("tie_i_after_ddone", 64'(t_irise - t_ddone), 64'd2);
      i_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 40 && (i_gnt || d_gnt); c++) @(negedge clk);
      chk("tie_drain", {62'd0, i_gnt, d_gnt}, 64'd0);
      tick();

      // Cancel an I refill during its second XFER with a D refill pending.
      do_reset();
      iq.delete(); dq.delete();
      sb_en = 1'b1;
      i_adr = 32'h40; i_req = 1'b1;
      iq.push_back(64'd8);
      wait_gnt(1'b0, ok);
      n_irv = 0; n_idone = 0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) begin d_we = 1'b0; d_adr = 64'h200; d_req = 1'b1; end
         @(negedge clk);
         n_irv += int'(i_rvalid); n_idone += int'(i_done);
      end
      tick();
      i_cancel = 1'b1; i_req = 1'b0;
      @(negedge clk);
      chk("cancel_k7_gnt", {62'd0, i_gnt, d_gnt}, 64'b10);
      tick();
      i_cancel = 1'b0;
      for (int b = 0; b < BEATS; b++) dq.push_back(64'd64 + 64'(b));
      @(negedge clk);
      chk("cancel_k8_idle", {60'd0, i_gnt, d_gnt, i_rvalid, i_done}, 64'd0);
      @(negedge clk);
      chk("cancel_k9_dgnt", {62'd0, i_gnt, d_gnt}, 64'b01);
      cyc = 0;
      while (!d_done && cyc < 40) begin
         @(negedge clk);
         n_irv += int'(i_rvalid); n_idone += int'(i_done);
         cyc++;
      end
      chk("cancel_d_done", {63'd0, d_done}, 64'd1);
      d_req = 1'b0;
      chk("cancel_i_rvalid_count", 64'(n_irv), 64'd1);
      chk("cancel_no_i_done", 64'(n_idone), 64'd0);
      @(negedge clk);
      chk("sb_queues_empty", 64'(iq.size() + dq.size() + wq_adr.size()), 64'd0);
      tick();

      // Reset in the middle of a D writeback.
      sb_en = 1'b0;
      ram_init = 1'b1;
      tick();
      ram_init = 1'b0;
      d_we = 1'b1; d_adr = 64'h100; d_req = 1'b1;
      wait_gnt(1'b1, ok);
      for (int k = 1; k <= 4; k++) @(negedge clk);
      tick();
      reset = 1'b0; d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midreset_ctl", {56'd0, i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_write}, 64'd0);
      chk("midreset_beat", 64'(beat), 64'd0);
      chk("midreset_rdata", rdata, 64'd0);
      tick();
      reset = 1'b1;
      chk("midreset_ram32", ram[32], 64'hA0);
      chk("midreset_ram33", ram[33], 64'd33);
      chk("midreset_ram34", ram[34], 64'd34);
      d_we = 1'b0; d_adr = 64'h200; i_adr = 32'h40;
      i_req = 1'b1; d_req = 1'b1;
      for (int c = 0; c < 10 && !(i_gnt || d_gnt); c++) @(negedge clk);
      chk("post_reset_tie", {62'd0, i_gnt, d_gnt}, 64'b01);
      i_req = 1'b0;
      for (int c = 0; c < 40 && !d_done; c++) @(negedge clk);
      chk("post_reset_d_done", {63'd0, d_done}, 64'd1);
      d_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
